// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic array skew feeder.
package systolic_pkg;

    localparam int unsigned WORD_SIZE_DEF = 8;
    localparam int unsigned ARRAY_N_DEF   = 4;
    localparam int unsigned MAC_LAT_DEF   = 1;
    localparam int unsigned MAX_K_DEF     = 256;

    // Cycles spent draining zeros after the final beat, for the default geometry.
    localparam int unsigned FLUSH_CYC = 2 * ARRAY_N_DEF - 2 + MAC_LAT_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

    // Low bit of lane i in a packed lane bus: lane(i) = [lane_lsb(i,w) +: w].
    function automatic int unsigned lane_lsb(input int unsigned i, input int unsigned w);
        return i * w;
    endfunction

    // Last beat needs 2N-2 hops to reach PE(N-1,N-1), then MAC_LAT to accumulate.
    function automatic int unsigned flush_cycles(input int unsigned n, input int unsigned lat);
        return 2 * n - 2 + lat;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Zero-reset shift register that delays one lane by DEPTH cycles.
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_SIZE_DEF,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the lane one stage per cycle; reset flushes to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < int'(DEPTH); s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds k-slices into the systolic array edges with diagonal skew and sequences clear/flush/done.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned word_size = WORD_SIZE_DEF,
    parameter int unsigned ARRAY_N   = ARRAY_N_DEF,
    parameter int unsigned MAC_LAT   = MAC_LAT_DEF,
    parameter int unsigned MAX_K     = MAX_K_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ARRAY_N*word_size-1:0]   in_a,
    input  logic [ARRAY_N*word_size-1:0]   in_b,
    input  logic                           in_last,
    output logic [ARRAY_N*word_size-1:0]   a_out,
    output logic [ARRAY_N*word_size-1:0]   b_out,
    output logic                           clear_out,
    output logic [$clog2(MAX_K+1)-1:0]     k_count,
    output logic                           tile_done,
    input  logic                           done_ack
);

    localparam int unsigned KW      = $clog2(MAX_K + 1);
    localparam int unsigned FL_CYC  = flush_cycles(ARRAY_N, MAC_LAT);
    localparam int unsigned FW      = (FL_CYC > 1) ? $clog2(FL_CYC + 1) : 1;

    feeder_state_e  state_q, state_d;
    logic [KW-1:0]  k_count_q, k_count_d;
    logic [FW-1:0]  flush_cnt_q, flush_cnt_d;
    logic           in_ready_q, in_ready_d;
    logic           clear_q, clear_d;
    logic           done_q, done_d;

    logic           accept;
    logic           beat_end;
    logic           flush_end;

    assign accept    = (state_q == ST_FEED) && in_valid;
    assign beat_end  = accept && (in_last || (k_count_q == KW'(MAX_K - 1)));
    assign flush_end = (flush_cnt_q == FW'(FL_CYC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_CLEAR;
            ST_CLEAR:                state_d = ST_FEED;
            ST_FEED:  if (beat_end)  state_d = ST_FLUSH;
            ST_FLUSH: if (flush_end) state_d = ST_DONE;
            ST_DONE:  if (done_ack)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register alongside it.
    always_comb begin
        in_ready_d = 1'b0;
        clear_d    = 1'b0;
        done_d     = 1'b0;
        unique case (state_d)
            ST_CLEAR: clear_d    = 1'b1;
            ST_FEED:  in_ready_d = 1'b1;
            ST_DONE:  done_d     = 1'b1;
            default:  ;
        endcase
    end

    // Beat counter restarts on clear; flush counter runs only while draining.
    always_comb begin
        k_count_d   = k_count_q;
        flush_cnt_d = '0;
        if (state_q == ST_CLEAR) begin
            k_count_d = '0;
        end else if (accept) begin
            k_count_d = k_count_q + KW'(1);
        end
        if (state_q == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q + FW'(1);
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            k_count_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            k_count_q   <= k_count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign clear_out = clear_q;
    assign tile_done = done_q;
    assign k_count   = k_count_q;

    // Lane i gets i+1 stages; non-accepted cycles inject a neutral zero bubble.
    for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(32'(g), word_size);

        logic [word_size-1:0] a_inj;
        logic [word_size-1:0] b_inj;

        assign a_inj = accept ? in_a[LSB +: word_size] : '0;
        assign b_inj = accept ? in_b[LSB +: word_size] : '0;

        skew_delay_line #(
            .WIDTH (word_size),
            .DEPTH (32'(g + 1))
        ) u_a_line (
            .clk   (clk),
            .reset (reset),
            .d_i   (a_inj),
            .q_o   (a_out[LSB +: word_size])
        );

        skew_delay_line #(
            .WIDTH (word_size),
            .DEPTH (32'(g + 1))
        ) u_b_line (
            .clk   (clk),
            .reset (reset),
            .d_i   (b_inj),
            .q_o   (b_out[LSB +: word_size])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a timeline reference model.
module tb_systolic_skew_feeder;

    localparam int unsigned N    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned LAT  = 1;
    localparam int unsigned MAXK = 4;
    localparam int unsigned KW   = $clog2(MAXK + 1);
    localparam int unsigned BW   = N * W;
    localparam int          FL   = 2 * N - 2 + LAT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          in_last = 1'b0;
    logic [BW-1:0] a_out;
    logic [BW-1:0] b_out;
    logic          clear_out;
    logic [KW-1:0] k_count;
    logic          tile_done;
    logic          done_ack = 1'b0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .word_size (W),
        .ARRAY_N   (N),
        .MAC_LAT   (LAT),
        .MAX_K     (MAXK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .a_out     (a_out),
        .b_out     (b_out),
        .clear_out (clear_out),
        .k_count   (k_count),
        .tile_done (tile_done),
        .done_ack  (done_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tile phase timeline plus history of values injected at lane 0.
    typedef enum int {P_IDLE, P_CLEAR, P_FEED, P_FLUSH, P_DONE} phase_t;
    phase_t        m_phase = P_IDLE;
    int            m_k = 0;
    int            m_flush_left = 0;
    logic [BW-1:0] hist_a[$];
    logic [BW-1:0] hist_b[$];
    int            exp_sum[N][N];

    logic          e_ready, e_clr, e_done, e_done_prev;
    logic [KW-1:0] e_k;
    logic [BW-1:0] e_a, e_b;

    // Behavioural array driven by the observed edges: PE(i,j) sees a lane i delayed j, b lane j delayed i.
    logic [BW-1:0] obs_a[$];
    logic [BW-1:0] obs_b[$];
    int            acc[N][N];
    logic          obs_done_prev = 1'b0;
    int            edge_no = 0;
    int            last_acc_edge = -1;
    bit            chk_en = 1'b0;

    logic [BW-1:0] tq_a[$];
    logic [BW-1:0] tq_b[$];

    function automatic logic [W-1:0] lane_of(input logic [BW-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    task automatic model_step(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                              input logic last, input logic ack, input logic rst);
        logic [BW-1:0] ia;
        logic [BW-1:0] ib;
        logic [BW-1:0] ha;
        logic [BW-1:0] hb;
        ia = '0;
        ib = '0;
        if (rst) begin
            m_phase = P_IDLE;
            m_k = 0;
            hist_a.delete();
            hist_b.delete();
            for (int i = 0; i < int'(N); i++) begin
                hist_a.push_back('0);
                hist_b.push_back('0);
            end
        end else begin
            case (m_phase)
                P_IDLE:  if (v) m_phase = P_CLEAR;
                P_CLEAR: begin
                    m_k = 0;
                    for (int i = 0; i < int'(N); i++)
                        for (int j = 0; j < int'(N); j++) exp_sum[i][j] = 0;
                    m_phase = P_FEED;
                end
                P_FEED: if (v) begin
                    ia = a;
                    ib = b;
                    m_k++;
                    for (int i = 0; i < int'(N); i++)
                        for (int j = 0; j < int'(N); j++)
                            exp_sum[i][j] += int'(lane_of(a, i)) * int'(lane_of(b, j));
                    if (last || m_k == int'(MAXK)) begin
                        m_phase = P_FLUSH;
                        m_flush_left = FL;
                    end
                end
                P_FLUSH: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_phase = P_DONE;
                end
                P_DONE: if (ack) m_phase = P_IDLE;
                default: m_phase = P_IDLE;
            endcase
            hist_a.push_back(ia);
            hist_b.push_back(ib);
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
        end
        e_ready = (m_phase == P_FEED);
        e_clr   = (m_phase == P_CLEAR);
        e_done  = (m_phase == P_DONE);
        e_k     = KW'(m_k);
        for (int i = 0; i < int'(N); i++) begin
            ha = hist_a[hist_a.size() - 1 - i];
            hb = hist_b[hist_b.size() - 1 - i];
            e_a[i*W +: W] = ha[i*W +: W];
            e_b[i*W +: W] = hb[i*W +: W];
        end
    endtask

    // One clock: compare outputs, run the observed array, drive inputs, advance model.
    task automatic cycle(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic last, input logic ack, input logic rst);
        logic [BW-1:0] pa;
        logic [BW-1:0] pb;
        if (chk_en) begin
            check_eq("in_ready", 64'(in_ready), 64'(e_ready));
            check_eq("clear_out", 64'(clear_out), 64'(e_clr));
            check_eq("tile_done", 64'(tile_done), 64'(e_done));
            check_eq("k_count", 64'(k_count), 64'(e_k));
            check_eq("a_out", 64'(a_out), 64'(e_a));
            check_eq("b_out", 64'(b_out), 64'(e_b));
        end
        obs_a.push_back(a_out);
        obs_b.push_back(b_out);
        void'(obs_a.pop_front());
        void'(obs_b.pop_front());
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (clear_out === 1'b1) begin
                    acc[i][j] = 0;
                end else begin
                    pa = obs_a[obs_a.size() - 1 - j];
                    pb = obs_b[obs_b.size() - 1 - i];
                    acc[i][j] += int'(lane_of(pa, i)) * int'(lane_of(pb, j));
                end
            end
        end
        if (chk_en && e_done && !e_done_prev) begin
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++)
                    check_eq($sformatf("pe_sum_%0d_%0d", i, j), 64'(acc[i][j]), 64'(exp_sum[i][j]));
        end
        if (chk_en && tile_done === 1'b1 && obs_done_prev !== 1'b1 && last_acc_edge >= 0)
            check_eq("done_lat", 64'(edge_no - last_acc_edge), 64'(FL));
        obs_done_prev = tile_done;
        e_done_prev = e_done;
        if (in_ready === 1'b1 && v) last_acc_edge = edge_no + 1;
        if (rst) last_acc_edge = -1;

        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        done_ack = ack;
        reset    = rst;
        model_step(v, a, b, last, ack, rst);
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    function automatic logic [BW-1:0] rnd_bus();
        return BW'($urandom());
    endfunction

    // Play the beats queued in tq_a/tq_b as one tile, through done and ack.
    task automatic run_tile(input int gap_pct, input int ack_wait, input bit set_last, input bit valid_in_done);
        int budget;
        int waited;
        bit finished;
        logic v, last, ack;
        logic [BW-1:0] a, b;
        bit took;
        budget = 0;
        waited = 0;
        finished = 1'b0;
        while (!finished && budget < 300) begin
            budget++;
            v = 1'b0; last = 1'($urandom_range(1)); ack = 1'($urandom_range(1));
            a = rnd_bus(); b = rnd_bus();
            took = 1'b0;
            case (m_phase)
                P_IDLE, P_CLEAR, P_FEED: begin
                    ack = (m_phase == P_FEED) ? ack : 1'b0;
                    if (tq_a.size() > 0 &&
                        (m_phase != P_FEED || int'($urandom_range(99)) >= gap_pct)) begin
                        v = 1'b1; a = tq_a[0]; b = tq_b[0];
                        last = (tq_a.size() == 1) && set_last;
                        took = (m_phase == P_FEED);
                    end
                end
                P_FLUSH: v = 1'($urandom_range(1));
                P_DONE: begin
                    v = valid_in_done;
                    ack = 1'b0;
                    if (waited >= ack_wait) begin
                        ack = 1'b1;
                        finished = 1'b1;
                    end else begin
                        waited++;
                    end
                end
                default: ;
            endcase
            cycle(v, a, b, last, ack, 1'b0);
            if (took) begin
                void'(tq_a.pop_front());
                void'(tq_b.pop_front());
            end
        end
        check_eq("tile_completes", 64'(finished), 64'(1));
        tq_a.delete();
        tq_b.delete();
    endtask

    task automatic queue_random(input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            tq_a.push_back(rnd_bus());
            tq_b.push_back(rnd_bus());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        for (int i = 0; i < int'(N); i++) begin
            obs_a.push_back('0);
            obs_b.push_back('0);
            for (int j = 0; j < int'(N); j++) begin
                acc[i][j] = 0;
                exp_sum[i][j] = 0;
            end
        end
        e_done_prev = 1'b0;
        @(negedge clk);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, '1, '1, 1'b1, 1'b1, 1'b1);

        // Two-beat tile with counting lanes.
        tq_a.push_back(32'h04030201); tq_b.push_back(32'h14131211);
        tq_a.push_back(32'h08070605); tq_b.push_back(32'h18171615);
        run_tile(0, 0, 1'b1, 1'b0);

        // Bubbles inside the tile.
        queue_random(4);
        run_tile(40, 1, 1'b1, 1'b0);

        // Single beat a=3, b=4 on every lane.
        tq_a.push_back({4{8'd3}}); tq_b.push_back({4{8'd4}});
        run_tile(0, 0, 1'b1, 1'b0);

        // Hold done_ack low while in_valid is high, then a back-to-back tile.
        queue_random(2);
        run_tile(0, 5, 1'b1, 1'b1);
        queue_random(3);
        run_tile(0, 0, 1'b1, 1'b0);

        // MAX_K beats with no in_last forces the flush.
        queue_random(int'(MAXK));
        run_tile(20, 0, 1'b0, 1'b0);

        // Reset during FEED aborts the tile.
        queue_random(4);
        for (int c = 0; c < 40 && !(m_phase == P_FEED && m_k == 2); c++) begin
            logic took;
            took = (m_phase == P_FEED);
            cycle(1'b1, tq_a[0], tq_b[0], 1'b0, 1'b0, 1'b0);
            if (took) begin
                void'(tq_a.pop_front());
                void'(tq_b.pop_front());
            end
        end
        cycle(1'b1, rnd_bus(), rnd_bus(), 1'b0, 1'b0, 1'b1);
        tq_a.delete(); tq_b.delete();
        cycle(1'b0, rnd_bus(), rnd_bus(), 1'b0, 1'b0, 1'b0);
        queue_random(3);
        run_tile(0, 0, 1'b1, 1'b0);

        // Random tiles.
        for (int t = 0; t < 15; t++) begin
            nb = int'($urandom_range(1, MAXK));
            queue_random(nb);
            run_tile(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                     (nb < int'(MAXK)) ? 1'b1 : 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
